// File: rtl/imem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : imem_arbiter
// Purpose  : Shares one instruction-memory port between two requesters
//            (0 = fetch PC stage, 1 = prefetch/debug reader). Requests are
//            arbitrated round-robin and a grant stays locked until memory
//            accepts it. An in-order owner FIFO routes each response back to
//            the requester that issued it. A per-requester flush kills that
//            requester's in-flight responses; killed responses are drained
//            from memory and never forwarded.
// Ports    : clk, rst_n                  clock, async active-low reset
//            rq_valid_i/rq_ready_o       per-requester request handshake
//            rq_addr0_i/rq_addr1_i       requester addresses
//            rs_valid_o/rs_ready_i       per-requester response handshake
//            rs_inst_o                   shared response data
//            flush_i                     per-requester kill of in-flight work
//            imem_req_*                  memory request channel
//            imem_resp_*                 memory response channel
//            outstanding_o               live owner-FIFO entries
//            err_spurious_o              sticky: response with empty FIFO
// Revision : 1.0  initial release
// ============================================================================
module imem_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4     // power of 2, >= 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [1:0]                         rq_valid_i,
    output logic [1:0]                         rq_ready_o,
    input  logic [ADDR_W-1:0]                  rq_addr0_i,
    input  logic [ADDR_W-1:0]                  rq_addr1_i,
    output logic [1:0]                         rs_valid_o,
    input  logic [1:0]                         rs_ready_i,
    output logic [DATA_W-1:0]                  rs_inst_o,
    input  logic [1:0]                         flush_i,
    output logic                               imem_req_valid_o,
    input  logic                               imem_req_ready_i,
    output logic [ADDR_W-1:0]                  imem_req_addr_o,
    input  logic                               imem_resp_valid_i,
    output logic                               imem_resp_ready_o,
    input  logic [DATA_W-1:0]                  imem_resp_inst_i,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
    output logic                               err_spurious_o
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]                 state_q, state_d;
    logic                       lock_q, lock_d;     // requester locked in HOLD
    logic                       rr_q, rr_d;         // favoured requester
    logic [MAX_OUTSTANDING-1:0] owner_q, owner_d;
    logic [MAX_OUTSTANDING-1:0] killed_q, killed_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       err_q, err_d;

    // ------------------------------------------------------------------
    // Combinational wires
    // ------------------------------------------------------------------
    logic full_w;
    logic empty_w;
    logic req_valid_w;
    logic gnt_w;
    logic push_w;
    logic pop_w;
    logic head_owner_w;
    logic head_killed_w;
    logic spurious_w;

    assign full_w       = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign empty_w      = (count_q == '0);
    assign head_owner_w = owner_q[rd_ptr_q];
    // A flush in this cycle already kills the head, so a response presented
    // to a requester that is being flushed is drained instead of delivered.
    assign head_killed_w = killed_q[rd_ptr_q] | flush_i[head_owner_w];

    // Request side: grant selection. Outputs are gated by rst_n so that the
    // request channel drops immediately when reset is asserted, even if the
    // requesters keep their valids high.
    always_comb begin
        req_valid_w = 1'b0;
        gnt_w       = rr_q;
        if (rst_n) begin
            if (state_q == S_HOLD) begin
                req_valid_w = 1'b1;
                gnt_w       = lock_q;
            end else if (!full_w && (rq_valid_i != 2'b00)) begin
                req_valid_w = 1'b1;
                gnt_w       = rq_valid_i[rr_q] ? rr_q : ~rr_q;
            end
        end
    end

    assign push_w           = req_valid_w & imem_req_ready_i;
    assign imem_req_valid_o = req_valid_w;
    assign imem_req_addr_o  = !req_valid_w ? '0 :
                              (gnt_w ? rq_addr1_i : rq_addr0_i);
    assign rq_ready_o       = !push_w ? 2'b00 : (gnt_w ? 2'b10 : 2'b01);

    // Response side: route or drain based on the FIFO head.
    always_comb begin
        rs_valid_o        = 2'b00;
        rs_inst_o         = '0;
        imem_resp_ready_o = 1'b0;
        spurious_w        = 1'b0;
        if (rst_n) begin
            if (empty_w) begin
                imem_resp_ready_o = 1'b1;
                spurious_w        = imem_resp_valid_i;
            end else if (head_killed_w) begin
                imem_resp_ready_o = 1'b1;
            end else begin
                rs_valid_o[head_owner_w] = imem_resp_valid_i;
                rs_inst_o                = imem_resp_inst_i;
                imem_resp_ready_o        = rs_ready_i[head_owner_w];
            end
        end
    end

    assign pop_w = !empty_w & imem_resp_valid_i & imem_resp_ready_o;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // A request that is not accepted this cycle (IDLE or HOLD) keeps the
        // grant locked; any acceptance returns to IDLE.
        state_d = (req_valid_w && !imem_req_ready_i) ? S_HOLD : S_IDLE;
        lock_d  = req_valid_w ? gnt_w : lock_q;
        rr_d    = push_w ? ~gnt_w : rr_q;

        owner_d  = owner_q;
        killed_d = killed_q;
        // Stale (non-live) slots may also get marked; they are rewritten on
        // push so this is harmless.
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (flush_i[owner_q[i]]) begin
                killed_d[i] = 1'b1;
            end
        end
        if (push_w) begin
            owner_d[wr_ptr_q]  = gnt_w;
            killed_d[wr_ptr_q] = flush_i[gnt_w];
        end

        wr_ptr_d = push_w ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_w  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push_w) - CNT_W'(pop_w);
        err_d    = err_q | spurious_w;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            lock_q   <= 1'b0;
            rr_q     <= 1'b0;
            owner_q  <= '0;
            killed_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lock_q   <= lock_d;
            rr_q     <= rr_d;
            owner_q  <= owner_d;
            killed_q <= killed_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    assign outstanding_o  = count_q;
    assign err_spurious_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_imem_arbiter
// Purpose  : Self-checking bench for imem_arbiter. A transaction-level model
//            (queue of {owner, killed, addr} entries, a favoured-requester
//            index and a locked-grant index) predicts every output on every
//            cycle. Directed scenarios pin literal values; a randomized run
//            then exercises arbitration, back-pressure, full and flush.
// Revision : 1.0  initial release
// ============================================================================
module tb_imem_arbiter;

    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  rq_valid = '0;
    logic [1:0]  rq_ready;
    logic [31:0] addr0 = '0;
    logic [31:0] addr1 = '0;
    logic [1:0]  rs_valid;
    logic [1:0]  rs_ready = '0;
    logic [31:0] rs_inst;
    logic [1:0]  flush = '0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] req_addr;
    logic        resp_valid = 1'b0;
    logic        resp_ready;
    logic [31:0] resp_inst = '0;
    logic [2:0]  outstanding;
    logic        err;

    imem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(MAXO)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rq_valid_i        (rq_valid),
        .rq_ready_o        (rq_ready),
        .rq_addr0_i        (addr0),
        .rq_addr1_i        (addr1),
        .rs_valid_o        (rs_valid),
        .rs_ready_i        (rs_ready),
        .rs_inst_o         (rs_inst),
        .flush_i           (flush),
        .imem_req_valid_o  (req_valid),
        .imem_req_ready_i  (req_ready),
        .imem_req_addr_o   (req_addr),
        .imem_resp_valid_i (resp_valid),
        .imem_resp_ready_o (resp_ready),
        .imem_resp_inst_i  (resp_inst),
        .outstanding_o     (outstanding),
        .err_spurious_o    (err)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Scoring
    // ------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    typedef struct packed {
        bit          owner;
        bit          killed;
        logic [31:0] addr;
    } ent_t;

    ent_t mq[$];
    int   m_rr   = 0;     // favoured requester
    int   m_lock = -1;    // requester whose request is pending acceptance
    bit   m_err  = 0;
    bit   pend[2];        // random-stimulus requester has a request waiting

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_rr   = 0;
        m_lock = -1;
        m_err  = 0;
        pend[0] = 0;
        pend[1] = 0;
    endtask

    // Predict this cycle's outputs from the current inputs, compare, then
    // advance the model as of the coming rising edge.
    task automatic model_step();
        bit          e_reqv, e_rspr, hk, ho;
        bit [1:0]    e_rqr, e_rsv;
        logic [31:0] e_addr, e_inst;
        int          g;
        ent_t        ne;

        e_reqv = (m_lock >= 0) || (mq.size() < MAXO && rq_valid != 2'b00);
        if (m_lock >= 0)          g = m_lock;
        else if (rq_valid[m_rr])  g = m_rr;
        else                      g = 1 - m_rr;
        e_addr = (g == 0) ? addr0 : addr1;
        e_rqr  = (e_reqv && req_ready) ? (2'b01 << g) : 2'b00;

        e_rsv  = 2'b00;
        e_inst = '0;
        hk     = 0;
        ho     = 0;
        if (mq.size() == 0) begin
            e_rspr = 1'b1;
        end else begin
            ho = mq[0].owner;
            hk = mq[0].killed || flush[ho];
            if (hk) begin
                e_rspr = 1'b1;
            end else begin
                e_rsv  = resp_valid ? (2'b01 << ho) : 2'b00;
                e_inst = resp_inst;
                e_rspr = rs_ready[ho];
            end
        end

        chk("imem_req_valid", req_valid, e_reqv);
        if (e_reqv) chk("imem_req_addr", req_addr, e_addr);
        chk("rq_ready", rq_ready, e_rqr);
        chk("imem_resp_ready", resp_ready, e_rspr);
        chk("rs_valid", rs_valid, e_rsv);
        if (e_rsv != 2'b00) chk("rs_inst", rs_inst, e_inst);
        chk("outstanding", outstanding, mq.size());
        chk("err_spurious", err, m_err);

        // Edge update: flush, then pop (the full check above already used
        // the pre-pop occupancy), then push.
        foreach (mq[i]) if (flush[mq[i].owner]) mq[i].killed = 1;
        if (resp_valid && e_rspr) begin
            if (mq.size() == 0) m_err = 1;
            else                void'(mq.pop_front());
        end
        if (e_reqv) begin
            if (req_ready) begin
                ne.owner  = g[0];
                ne.killed = flush[g];
                ne.addr   = e_addr;
                mq.push_back(ne);
                m_rr   = 1 - g;
                m_lock = -1;
                pend[g] = 0;
            end else begin
                m_lock = g;
            end
        end
    endtask

    task automatic cyc(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1,
                       input logic rqr, input logic mv, input logic [31:0] mi,
                       input logic [1:0] rsr, input logic [1:0] fl);
        @(negedge clk);
        rq_valid   = v;
        addr0      = a0;
        addr1      = a1;
        req_ready  = rqr;
        resp_valid = mv;
        resp_inst  = mi;
        rs_ready   = rsr;
        flush      = fl;
        #1;
        model_step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        rq_valid   = '0;
        flush      = '0;
        rs_ready   = '0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_inst  = 32'h1234_5678;
        #1;
        chk("reset rq_ready", rq_ready, 2'b00);
        chk("reset rs_valid", rs_valid, 2'b00);
        chk("reset imem_req_valid", req_valid, 1'b0);
        chk("reset imem_resp_ready", resp_ready, 1'b0);
        chk("reset imem_req_addr", req_addr, 32'h0);
        chk("reset rs_inst", rs_inst, 32'h0);
        chk("reset outstanding", outstanding, 3'd0);
        chk("reset err_spurious", err, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        model_reset();

        // Single request / response
        do_reset();
        cyc(2'b01, 32'h100, 32'h0, 1'b1, 1'b0, 32'h0, 2'b11, 2'b00);
        chk("single rq_ready", rq_ready, 2'b01);
        chk("single addr", req_addr, 32'h100);
        @(posedge clk); #1;
        chk("single outstanding after push", outstanding, 3'd1);
        cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 2'b11, 2'b00);
        chk("single rs_valid", rs_valid, 2'b01);
        chk("single rs_inst", rs_inst, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        chk("single outstanding after pop", outstanding, 3'd0);

        // Round-robin, then full
        do_reset();
        cyc(2'b11, 32'h10, 32'h20, 1'b1, 1'b0, 32'h0, 2'b11, 2'b00);
        chk("rr grant 1", rq_ready, 2'b01);
        cyc(2'b11, 32'h14, 32'h24, 1'b1, 1'b0, 32'h0, 2'b11, 2'b00);
        chk("rr grant 2", rq_ready, 2'b10);
        cyc(2'b11, 32'h18, 32'h28, 1'b1, 1'b0, 32'h0, 2'b11, 2'b00);
        chk("rr grant 3", rq_ready, 2'b01);
        cyc(2'b11, 32'h1C, 32'h2C, 1'b1, 1'b0, 32'h0, 2'b11, 2'b00);
        chk("rr grant 4", rq_ready, 2'b10);
        cyc(2'b11, 32'h30, 32'h40, 1'b1, 1'b0, 32'h0, 2'b11, 2'b00);
        chk("full req_valid", req_valid, 1'b0);
        chk("full outstanding", outstanding, 3'd4);
        cyc(2'b11, 32'h30, 32'h40, 1'b1, 1'b1, 32'hA000_0001, 2'b11, 2'b00);
        chk("rr resp owner 0", rs_valid, 2'b01);
        chk("full pop-cycle no grant", req_valid, 1'b0);
        cyc(2'b11, 32'h30, 32'h40, 1'b1, 1'b1, 32'hA000_0002, 2'b11, 2'b00);
        chk("rr resp owner 1", rs_valid, 2'b10);
        chk("grant resumes", rq_ready, 2'b01);
        cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hA000_0003, 2'b11, 2'b00);
        chk("rr resp owner 0 b", rs_valid, 2'b01);
        cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hA000_0004, 2'b11, 2'b00);
        chk("rr resp owner 1 b", rs_valid, 2'b10);
        cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hA000_0005, 2'b11, 2'b00);

        // Hold / lock
        do_reset();
        cyc(2'b01, 32'hA0, 32'hB0, 1'b0, 1'b0, 32'h0, 2'b11, 2'b00);
        chk("hold first addr", req_addr, 32'hA0);
        for (int i = 0; i < 3; i++) begin
            cyc(2'b11, 32'hA0, 32'hB0, 1'b0, 1'b0, 32'h0, 2'b11, 2'b00);
            chk("hold locked addr", req_addr, 32'hA0);
        end
        cyc(2'b11, 32'hA0, 32'hB0, 1'b1, 1'b0, 32'h0, 2'b11, 2'b00);
        chk("hold accept", rq_ready, 2'b01);
        cyc(2'b10, 32'h0, 32'hB0, 1'b1, 1'b0, 32'h0, 2'b11, 2'b00);
        chk("hold next grant", rq_ready, 2'b10);
        chk("hold next addr", req_addr, 32'hB0);

        // Flush of requester 0 with owners 0,1,0 in flight
        do_reset();
        cyc(2'b01, 32'h50, 32'h0, 1'b1, 1'b0, 32'h0, 2'b11, 2'b00);
        cyc(2'b10, 32'h0, 32'h60, 1'b1, 1'b0, 32'h0, 2'b11, 2'b00);
        cyc(2'b01, 32'h54, 32'h0, 1'b1, 1'b0, 32'h0, 2'b11, 2'b00);
        cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b11, 2'b01);
        cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hC001, 2'b11, 2'b00);
        chk("flush drain 1 rs_valid", rs_valid, 2'b00);
        chk("flush drain 1 ready", resp_ready, 1'b1);
        cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hC002, 2'b11, 2'b00);
        chk("flush deliver owner 1", rs_valid, 2'b10);
        chk("flush deliver data", rs_inst, 32'hC002);
        cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hC003, 2'b11, 2'b00);
        chk("flush drain 3 rs_valid", rs_valid, 2'b00);

        // Live head dropped when its owner flushes in the same cycle
        cyc(2'b10, 32'h0, 32'h70, 1'b1, 1'b0, 32'h0, 2'b11, 2'b00);
        cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hC004, 2'b00, 2'b10);
        chk("same-cycle flush gate", rs_valid, 2'b00);

        // Spurious response, then async reset in HOLD
        do_reset();
        cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hBAD, 2'b00, 2'b00);
        @(posedge clk); #1;
        chk("spurious sets err", err, 1'b1);
        cyc(2'b01, 32'h200, 32'h0, 1'b1, 1'b0, 32'h0, 2'b00, 2'b00);
        chk("err sticky", err, 1'b1);
        cyc(2'b10, 32'h0, 32'h300, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00);
        @(posedge clk); #2;
        chk("hold before reset", req_valid, 1'b1);
        chk("hold addr before reset", req_addr, 32'h300);
        rst_n = 1'b0;
        #1;
        chk("async reset req_valid", req_valid, 1'b0);
        chk("async reset err", err, 1'b0);
        chk("async reset outstanding", outstanding, 3'd0);
        model_reset();
        @(negedge clk);
        rq_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized run
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1;
                    if (i == 0) addr0 = $urandom;
                    else        addr1 = $urandom;
                end
            end
            rq_valid   = {pend[1], pend[0]};
            req_ready  = ($urandom_range(0, 9) < 6);
            flush[0]   = ($urandom_range(0, 15) == 0);
            flush[1]   = ($urandom_range(0, 15) == 0);
            rs_ready   = 2'($urandom_range(0, 3));
            resp_valid = (mq.size() > 0) && ($urandom_range(0, 9) < 7);
            resp_inst  = resp_valid ? mem_data(mq[0].addr) : $urandom;
            #1;
            model_step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
